// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the reduced 6502 core: FSM states, ALU ops,
// flag bit positions and the supported opcode set.
package cpu6502_pkg;

   typedef enum logic [2:0] {
      StRst0, StRst1, StFetch, StAdl, StAdh, StExec, StImpl
   } state_e;

   typedef enum logic [2:0] {
      AluPass, AluAdc, AluSbc, AluAnd, AluOra, AluEor, AluCmp, AluBit
   } alu_op_e;

   localparam int unsigned FlagC = 0;
   localparam int unsigned FlagZ = 1;
   localparam int unsigned FlagI = 2;
   localparam int unsigned FlagD = 3;
   localparam int unsigned FlagV = 6;
   localparam int unsigned FlagN = 7;

   localparam logic [7:0] PReset = 8'h34;

   localparam logic [7:0] OpLda = 8'hAD;
   localparam logic [7:0] OpLdx = 8'hAE;
   localparam logic [7:0] OpLdy = 8'hAC;
   localparam logic [7:0] OpSta = 8'h8D;
   localparam logic [7:0] OpStx = 8'h8E;
   localparam logic [7:0] OpSty = 8'h8C;
   localparam logic [7:0] OpAdc = 8'h6D;
   localparam logic [7:0] OpSbc = 8'hED;
   localparam logic [7:0] OpAnd = 8'h2D;
   localparam logic [7:0] OpOra = 8'h0D;
   localparam logic [7:0] OpEor = 8'h4D;
   localparam logic [7:0] OpCmp = 8'hCD;
   localparam logic [7:0] OpCpx = 8'hEC;
   localparam logic [7:0] OpCpy = 8'hCC;
   localparam logic [7:0] OpBit = 8'h2C;
   localparam logic [7:0] OpJmp = 8'h4C;
   localparam logic [7:0] OpClc = 8'h18;
   localparam logic [7:0] OpSec = 8'h38;
   localparam logic [7:0] OpCli = 8'h58;
   localparam logic [7:0] OpSei = 8'h78;
   localparam logic [7:0] OpClv = 8'hB8;
   localparam logic [7:0] OpCld = 8'hD8;
   localparam logic [7:0] OpSed = 8'hF8;

   // Opcodes carrying a two-byte absolute operand; everything else is a 2-cycle implied op.
   function automatic logic is_abs(input logic [7:0] op);
      case (op)
         OpLda, OpLdx, OpLdy, OpSta, OpStx, OpSty, OpAdc, OpSbc,
         OpAnd, OpOra, OpEor, OpCmp, OpCpx, OpCpy, OpBit, OpJmp: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu6502_alu.sv
// Combinational ALU: binary ADC/SBC, logic ops, compare and BIT, with N/V/Z/C outputs.
// AluPass forwards the memory operand so loads share the N/Z path.
module cpu6502_alu
   import cpu6502_pkg::*;
(
   input  logic [2:0] i_op,
   input  logic [7:0] i_r,
   input  logic [7:0] i_m,
   input  logic       i_c,
   output logic [7:0] o_res,
   output logic       o_n,
   output logic       o_v,
   output logic       o_z,
   output logic       o_c
);
   alu_op_e    w_op;
   logic [7:0] w_m_eff;
   logic [8:0] w_sum;
   logic       w_cin;

   assign w_op    = alu_op_e'(i_op);
   // SBC and CMP add the inverted operand; CMP always behaves as if carry were set.
   assign w_m_eff = (w_op == AluAdc) ? i_m : ~i_m;
   assign w_cin   = (w_op == AluCmp) ? 1'b1 : i_c;
   assign w_sum   = {1'b0, i_r} + {1'b0, w_m_eff} + {8'd0, w_cin};

   always_comb begin
      o_res = i_m;
      o_v   = 1'b0;
      o_c   = i_c;
      case (w_op)
         AluPass: o_res = i_m;
         AluAdc, AluSbc: begin
            o_res = w_sum[7:0];
            o_c   = w_sum[8];
            o_v   = (i_r[7] == w_m_eff[7]) && (w_sum[7] != i_r[7]);
         end
         AluAnd: o_res = i_r & i_m;
         AluOra: o_res = i_r | i_m;
         AluEor: o_res = i_r ^ i_m;
         AluCmp: begin
            o_res = w_sum[7:0];
            o_c   = w_sum[8];
         end
         AluBit: begin
            o_res = i_r & i_m;
            o_v   = i_m[6];
         end
         default: o_res = i_m;
      endcase
      o_n = (w_op == AluBit) ? i_m[7] : o_res[7];
      o_z = (o_res == 8'd0);
   end

endmodule

// File: rtl/cpu6502_core.sv
// Reduced 6502 core: absolute loads/stores/ALU ops, JMP abs, flag ops and NOP.
// Bus outputs are registered; rd_data is sampled at the end of each cycle.
module cpu6502_core
   import cpu6502_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR_LO = 16'hFFFC
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rd_data,
   output logic [15:0] address,
   output logic [7:0]  wr_data,
   output logic        wr_enable
);
   state_e      r_state;
   logic [15:0] r_pc;
   logic [15:0] r_address;
   logic [7:0]  r_a, r_x, r_y;
   logic [7:0]  r_opcode, r_adl, r_wr_data;
   logic        r_wr_enable;
   logic [7:0]  P;

   alu_op_e     w_alu_op;
   logic [7:0]  w_alu_r, w_alu_res;
   logic        w_n, w_v, w_z, w_c;
   logic [15:0] w_pc_inc;

   assign w_pc_inc  = r_pc + 16'd1;
   assign address   = r_address;
   assign wr_data   = r_wr_data;
   assign wr_enable = r_wr_enable;

   always_comb begin
      w_alu_op = AluPass;
      w_alu_r  = r_a;
      case (r_opcode)
         OpAdc: w_alu_op = AluAdc;
         OpSbc: w_alu_op = AluSbc;
         OpAnd: w_alu_op = AluAnd;
         OpOra: w_alu_op = AluOra;
         OpEor: w_alu_op = AluEor;
         OpCmp: w_alu_op = AluCmp;
         OpCpx: begin w_alu_op = AluCmp; w_alu_r = r_x; end
         OpCpy: begin w_alu_op = AluCmp; w_alu_r = r_y; end
         OpBit: w_alu_op = AluBit;
         default: ;
      endcase
   end

   cpu6502_alu u_alu (
      .i_op (w_alu_op),
      .i_r  (w_alu_r),
      .i_m  (rd_data),
      .i_c  (P[FlagC]),
      .o_res(w_alu_res),
      .o_n  (w_n),
      .o_v  (w_v),
      .o_z  (w_z),
      .o_c  (w_c)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= StRst0;
         r_address   <= RESET_VECTOR_LO;
         r_wr_data   <= 8'd0;
         r_wr_enable <= 1'b0;
         r_pc        <= 16'd0;
         r_a         <= 8'd0;
         r_x         <= 8'd0;
         r_y         <= 8'd0;
         r_opcode    <= 8'd0;
         r_adl       <= 8'd0;
         P           <= PReset;
      end else begin
         r_wr_enable <= 1'b0;
         case (r_state)
            StRst0: begin
               r_pc[7:0] <= rd_data;
               r_address <= RESET_VECTOR_LO + 16'd1;
               r_state   <= StRst1;
            end
            StRst1: begin
               r_pc      <= {rd_data, r_pc[7:0]};
               r_address <= {rd_data, r_pc[7:0]};
               r_state   <= StFetch;
            end
            StFetch: begin
               r_opcode  <= rd_data;
               r_pc      <= w_pc_inc;
               r_address <= w_pc_inc;
               r_state   <= is_abs(rd_data) ? StAdl : StImpl;
            end
            StAdl: begin
               r_adl     <= rd_data;
               r_pc      <= w_pc_inc;
               r_address <= w_pc_inc;
               r_state   <= StAdh;
            end
            StAdh: begin
               r_address <= {rd_data, r_adl};
               if (r_opcode == OpJmp) begin
                  r_pc    <= {rd_data, r_adl};
                  r_state <= StFetch;
               end else begin
                  r_pc    <= w_pc_inc;
                  r_state <= StExec;
                  // Stores raise wr_enable for the EXEC cycle only.
                  case (r_opcode)
                     OpSta: begin r_wr_enable <= 1'b1; r_wr_data <= r_a; end
                     OpStx: begin r_wr_enable <= 1'b1; r_wr_data <= r_x; end
                     OpSty: begin r_wr_enable <= 1'b1; r_wr_data <= r_y; end
                     default: ;
                  endcase
               end
            end
            StExec: begin
               r_address <= r_pc;
               r_state   <= StFetch;
               case (r_opcode)
                  OpLda: begin r_a <= w_alu_res; P[FlagN] <= w_n; P[FlagZ] <= w_z; end
                  OpLdx: begin r_x <= w_alu_res; P[FlagN] <= w_n; P[FlagZ] <= w_z; end
                  OpLdy: begin r_y <= w_alu_res; P[FlagN] <= w_n; P[FlagZ] <= w_z; end
                  OpAdc, OpSbc: begin
                     r_a     <= w_alu_res;
                     P[FlagN] <= w_n;
                     P[FlagV] <= w_v;
                     P[FlagZ] <= w_z;
                     P[FlagC] <= w_c;
                  end
                  OpAnd, OpOra, OpEor: begin
                     r_a     <= w_alu_res;
                     P[FlagN] <= w_n;
                     P[FlagZ] <= w_z;
                  end
                  OpCmp, OpCpx, OpCpy: begin
                     P[FlagN] <= w_n;
                     P[FlagZ] <= w_z;
                     P[FlagC] <= w_c;
                  end
                  OpBit: begin
                     P[FlagN] <= w_n;
                     P[FlagV] <= w_v;
                     P[FlagZ] <= w_z;
                  end
                  default: ;
               endcase
            end
            StImpl: begin
               r_address <= r_pc;
               r_state   <= StFetch;
               case (r_opcode)
                  OpClc: P[FlagC] <= 1'b0;
                  OpSec: P[FlagC] <= 1'b1;
                  OpCli: P[FlagI] <= 1'b0;
                  OpSei: P[FlagI] <= 1'b1;
                  OpClv: P[FlagV] <= 1'b0;
                  OpCld: P[FlagD] <= 1'b0;
                  OpSed: P[FlagD] <= 1'b1;
                  default: ;
               endcase
            end
            default: begin
               r_address <= RESET_VECTOR_LO;
               r_state   <= StRst0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu6502_core.sv
// Self-checking bench: an instruction-level model builds the expected per-cycle bus trace
// for a directed prelude plus a random program, then a mid-store reset is exercised.
module tb_cpu6502_core;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [7:0]  rd_data;
   logic [15:0] address;
   logic [7:0]  wr_data;
   logic        wr_enable;

   logic [7:0]  mem [0:65535];
   logic [7:0]  mm  [0:65535];

   int checks = 0;
   int failures = 0;
   int cyc_idx = 0;

   always #5 clk = ~clk;

   cpu6502_core #(.RESET_VECTOR_LO(16'hFFFC)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .rd_data  (rd_data),
      .address  (address),
      .wr_data  (wr_data),
      .wr_enable(wr_enable)
   );

   assign rd_data = mem[address];
   always @(posedge clk) if (wr_enable) mem[address] <= wr_data;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wd;
      logic        chk;
      logic [7:0]  a, x, y, p;
   } cyc_t;

   cyc_t        exp_q[$];
   cyc_t        e;
   logic [7:0]  ma, mx, my, mp;
   logic [15:0] mpc;
   logic [15:0] loc;
   logic        trace_on = 1'b0;
   logic        trace_done = 1'b0;

   logic [7:0] abs_ops  [0:15] = '{8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h6D, 8'hED,
                                   8'h2D, 8'h0D, 8'h4D, 8'hCD, 8'hEC, 8'hCC, 8'h2C, 8'h4C};
   logic [7:0] impl_ops [0:7]  = '{8'h18, 8'h38, 8'h58, 8'h78, 8'hB8, 8'hD8, 8'hF8, 8'hEA};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_idx, act, req);
      end
   endtask

   function automatic bit has_operand(input logic [7:0] op);
      for (int i = 0; i < 16; i++) if (abs_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit is_defined(input logic [7:0] op);
      for (int i = 0; i < 8; i++) if (impl_ops[i] == op) return 1'b1;
      return has_operand(op);
   endfunction

   task automatic push(input logic [15:0] a, input logic we, input logic [7:0] wd,
                       input logic chk);
      cyc_t c;
      c.addr = a; c.we = we; c.wd = wd; c.chk = chk;
      c.a = ma; c.x = mx; c.y = my; c.p = mp;
      exp_q.push_back(c);
   endtask

   task automatic put(input logic [7:0] b);
      mem[loc] = b;
      mm[loc]  = b;
      loc      = loc + 16'd1;
   endtask

   task automatic set_nz(input logic [7:0] r);
      mp[7] = r[7];
      mp[1] = (r == 8'd0);
   endtask

   // One whole instruction: appends its bus cycles and applies its architectural effect.
   task automatic model_step();
      logic [7:0]  op, lo, hi, m, r, reg_v;
      logic [15:0] ea;
      int          s;
      op = mm[mpc];
      push(mpc, 1'b0, 8'd0, 1'b1);
      mpc = mpc + 16'd1;
      if (!has_operand(op)) begin
         push(mpc, 1'b0, 8'd0, 1'b0);
         case (op)
            8'h18: mp[0] = 1'b0;
            8'h38: mp[0] = 1'b1;
            8'h58: mp[2] = 1'b0;
            8'h78: mp[2] = 1'b1;
            8'hB8: mp[6] = 1'b0;
            8'hD8: mp[3] = 1'b0;
            8'hF8: mp[3] = 1'b1;
            default: ;
         endcase
         return;
      end
      push(mpc, 1'b0, 8'd0, 1'b0); lo = mm[mpc]; mpc = mpc + 16'd1;
      push(mpc, 1'b0, 8'd0, 1'b0); hi = mm[mpc]; mpc = mpc + 16'd1;
      ea = {hi, lo};
      if (op == 8'h4C) begin
         // JMP has no EXEC cycle, so the 3 cycles already pushed are the whole instruction.
         exp_q.delete(exp_q.size() - 1);
         push(mpc - 16'd1, 1'b0, 8'd0, 1'b0);
         mpc = ea;
         return;
      end
      if (op == 8'h8D || op == 8'h8E || op == 8'h8C) begin
         r = (op == 8'h8D) ? ma : (op == 8'h8E) ? mx : my;
         push(ea, 1'b1, r, 1'b0);
         mm[ea] = r;
         return;
      end
      push(ea, 1'b0, 8'd0, 1'b0);
      m = mm[ea];
      case (op)
         8'hAD: begin ma = m; set_nz(m); end
         8'hAE: begin mx = m; set_nz(m); end
         8'hAC: begin my = m; set_nz(m); end
         8'h6D, 8'hED: begin
            s  = (op == 8'h6D) ? int'(ma) + int'(m) + int'(mp[0])
                               : int'(ma) + (255 - int'(m)) + int'(mp[0]);
            r  = s[7:0];
            mp[6] = (op == 8'h6D) ? (((ma ^ r) & (m ^ r) & 8'h80) != 0)
                                  : (((ma ^ r) & (~m ^ r) & 8'h80) != 0);
            mp[0] = (s > 255);
            ma = r;
            set_nz(r);
         end
         8'h2D: begin ma = ma & m; set_nz(ma); end
         8'h0D: begin ma = ma | m; set_nz(ma); end
         8'h4D: begin ma = ma ^ m; set_nz(ma); end
         8'hCD, 8'hEC, 8'hCC: begin
            reg_v = (op == 8'hCD) ? ma : (op == 8'hEC) ? mx : my;
            mp[0] = (reg_v >= m);
            r = reg_v - m;
            set_nz(r);
         end
         8'h2C: begin mp[1] = ((ma & m) == 8'd0); mp[7] = m[7]; mp[6] = m[6]; end
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      if (trace_on && !trace_done) begin
         if (exp_q.size() == 0) begin
            trace_done = 1'b1;
         end else begin
            e = exp_q.pop_front();
            check("address", address, e.addr);
            check("wr_enable", wr_enable, e.we);
            if (e.we) check("wr_data", wr_data, e.wd);
            if (e.chk) begin
               check("reg_a", dut.r_a, e.a);
               check("reg_x", dut.r_x, e.x);
               check("reg_y", dut.r_y, e.y);
               check("reg_p", dut.P, e.p);
            end
            cyc_idx++;
         end
      end
   end

   initial begin
      logic [7:0]  op;
      logic [15:0] ea, tgt;
      int          pick, gap, loops;

      for (int i = 0; i < 65536; i++) begin
         op = 8'($urandom);
         mem[i] = op;
         mm[i]  = op;
      end
      // Directed prelude at 0200.
      loc = 16'h0200;
      put(8'hAD); put(8'h00); put(8'h03);   // LDA $0300
      put(8'h8D); put(8'h10); put(8'h03);   // STA $0310
      put(8'h18);                           // CLC
      put(8'hAD); put(8'h02); put(8'h03);   // LDA $0302
      put(8'h6D); put(8'h03); put(8'h03);   // ADC $0303
      put(8'hAD); put(8'h04); put(8'h03);   // LDA $0304
      put(8'hCD); put(8'h05); put(8'h03);   // CMP $0305
      put(8'hFF);                           // undefined
      put(8'h4C); put(8'h00); put(8'h10);   // JMP $1000
      loc = 16'h0300; put(8'h80);
      loc = 16'h0302; put(8'h7F); put(8'h01); put(8'h40); put(8'h40);

      loc = 16'h1000;
      for (int i = 0; i < 250; i++) begin
         pick = $urandom_range(0, 9);
         if (pick <= 5) begin
            ea = 16'h8000 | 16'($urandom_range(0, 255));
            put(abs_ops[$urandom_range(0, 14)]); put(ea[7:0]); put(ea[15:8]);
         end else if (pick <= 7) begin
            put(impl_ops[$urandom_range(0, 7)]);
         end else if (pick == 8) begin
            do op = 8'($urandom); while (is_defined(op));
            put(op);
         end else begin
            gap = $urandom_range(0, 2);
            tgt = loc + 16'd3 + 16'(gap);
            put(8'h4C); put(tgt[7:0]); put(tgt[15:8]);
            for (int g = 0; g < gap; g++) put(8'($urandom));
         end
      end
      put(8'h4C); put(8'hFA); put(8'hFF);
      // Top of memory runs through the reset vector bytes and wraps to 0000.
      loc = 16'hFFFA;
      put(8'hEA); put(8'h38); put(8'h00); put(8'h02); put(8'h18); put(8'hEA);
      put(8'h4C); put(8'h00); put(8'h0F);
      loc = 16'h0F00;
      put(8'h4C); put(8'h00); put(8'h0F);

      ma = 8'd0; mx = 8'd0; my = 8'd0; mp = 8'h34;
      push(16'hFFFC, 1'b0, 8'd0, 1'b1);
      push(16'hFFFD, 1'b0, 8'd0, 1'b0);
      mpc = {mm[16'hFFFD], mm[16'hFFFC]};
      loops = 0;
      for (int n = 0; n < 3000 && loops < 3; n++) begin
         if (mpc == 16'h0F00) loops++;
         model_step();
      end

      // Hand-computed pins on the model trace.
      check("pin_rst0_addr", exp_q[0].addr, 16'hFFFC);
      check("pin_rst1_addr", exp_q[1].addr, 16'hFFFD);
      check("pin_fetch0_addr", exp_q[2].addr, 16'h0200);
      check("pin_lda_next_fetch", exp_q[6].addr, 16'h0203);
      check("pin_lda_a", exp_q[6].a, 8'h80);
      check("pin_lda_p", exp_q[6].p, 8'hB4);
      check("pin_sta_cycle", {exp_q[9].we, exp_q[9].addr, exp_q[9].wd}, {1'b1, 16'h0310, 8'h80});
      check("pin_adc_a", exp_q[20].a, 8'h80);
      check("pin_adc_p", exp_q[20].p, 8'hF4);
      check("pin_cmp_p", exp_q[28].p, 8'h77);
      check("pin_undef_fetch", exp_q[30].addr, 16'h0214);
      check("pin_undef_p", exp_q[30].p, 8'h77);
      check("pin_jmp_target", exp_q[33].addr, 16'h1000);

      #1 resetn = 1'b0;
      repeat (4) @(posedge clk);
      #2 resetn = 1'b1;
      trace_on = 1'b1;
      for (int k = 0; k < 6000 && !trace_done; k++) @(posedge clk);
      check("trace_complete", trace_done, 1'b1);
      trace_on = 1'b0;

      // Abort a store mid-EXEC with an asynchronous reset.
      @(posedge clk); #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
      check("rst_again_addr", address, 16'hFFFC);
      for (int k = 0; k < 100 && !wr_enable; k++) begin
         @(posedge clk); #2;
      end
      check("store_seen", wr_enable, 1'b1);
      resetn = 1'b0;
      #1;
      check("abort_addr", address, 16'hFFFC);
      check("abort_wr_enable", wr_enable, 1'b0);
      @(posedge clk); #2;
      check("held_wr_enable", wr_enable, 1'b0);
      resetn = 1'b1;
      check("rel_rst0_addr", address, 16'hFFFC);
      @(posedge clk); #2;
      check("rel_rst1_addr", address, 16'hFFFD);
      @(posedge clk); #2;
      check("rel_fetch_addr", address, 16'h0200);
      check("rel_reg_p", dut.P, 8'h34);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
